alu_flag_reg: RTL and testbench

Processor status register directly downstream of the ALU flag generator. It captures the 8-bit flag vector (bit0 Zero, bit1 Carry, bit2 Equal, bit3 Less, bit4 Greater, bits 7:5 reserved) under a per-bit write mask. It provides a small LIFO for saving and restoring flags across interrupts and calls, and evaluates branch conditions for the sequencer.

---
 rtl/alu_flag_reg_pkg.sv | 41 ++++
 rtl/alu_flag_stack.sv | 80 ++++++++
 rtl/alu_flag_reg.sv | 70 +++++++
 tb/tb_alu_flag_reg.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_flag_reg_pkg.sv
// Shared definitions for the processor status register: flag bit positions,
// the implemented-bit mask and branch condition encodings.
package alu_flag_reg_pkg;

  localparam int FLG_Z  = 0;
  localparam int FLG_C  = 1;
  localparam int FLG_EQ = 2;
  localparam int FLG_LT = 3;
  localparam int FLG_GT = 4;

  localparam logic [7:0] FLAG_RSV_MASK = 8'h1F;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_EQ     = 3'd5,
    COND_LT     = 3'd6,
    COND_GT     = 3'd7
  } cond_e;

  function automatic logic eval_cond(input logic [7:0] flags, input logic [2:0] sel);
    logic res;
    res = 1'b1;
    case (cond_e'(sel))
      COND_ALWAYS: res = 1'b1;
      COND_Z:      res = flags[FLG_Z];
      COND_NZ:     res = ~flags[FLG_Z];
      COND_C:      res = flags[FLG_C];
      COND_NC:     res = ~flags[FLG_C];
      COND_EQ:     res = flags[FLG_EQ];
      COND_LT:     res = flags[FLG_LT];
      COND_GT:     res = flags[FLG_GT];
      default:     res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_flag_stack.sv
// Flag save/restore LIFO: non-wrapping pointer, full/empty, push+pop swap
// and sticky overflow/underflow error flags.
module alu_flag_stack
  import alu_flag_reg_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  input  logic [FLAG_W-1:0] din,
  output logic              pop_vld,
  output logic [FLAG_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   SP_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   SP_ONE  = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;

  logic [FLAG_W-1:0] mem [DEPTH];
  logic [AW:0]       sp;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic              do_push;
  logic              do_swap;
  logic              ovf_set;
  logic              unf_set;

  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  assign wr_idx  = sp[AW-1:0];
  // At sp==DEPTH the low bits are 0, so top_idx wraps to DEPTH-1 as intended.
  assign top_idx = wr_idx - IDX_ONE;
  assign dout    = mem[top_idx];

  assign pop_vld = pop && !empty;
  assign do_push = push && !pop && !full;
  assign do_swap = push && pop && !empty;
  assign ovf_set = push && !pop && full;
  assign unf_set = pop && empty;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_idx] <= din;
    else if (do_swap)
      mem[top_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (do_push)
        sp <= sp + SP_ONE;
      else if (pop_vld && !push)
        sp <= sp - SP_ONE;

      if (ovf_set)
        ovf <= 1'b1;
      else if (err_clr)
        ovf <= 1'b0;

      if (unf_set)
        unf <= 1'b1;
      else if (err_clr)
        unf <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_flag_reg.sv
// Processor status register: masked flag capture, software load, stack
// restore with priority, and branch condition evaluation.
module alu_flag_reg
  import alu_flag_reg_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              flags_we,
  input  logic [FLAG_W-1:0] flags_mask,
  input  logic              psw_ld,
  input  logic [FLAG_W-1:0] psw_din,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  input  logic [2:0]        cond_sel,
  output logic [FLAG_W-1:0] flags_out,
  output logic              cond_true,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_ovf,
  output logic              stk_unf
);

  logic              pop_vld;
  logic [FLAG_W-1:0] stk_dout;
  logic [FLAG_W-1:0] flags_nxt;

  alu_flag_stack #(
    .DEPTH  (DEPTH),
    .FLAG_W (FLAG_W)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .err_clr (err_clr),
    .din     (flags_out),
    .pop_vld (pop_vld),
    .dout    (stk_dout),
    .full    (stk_full),
    .empty   (stk_empty),
    .ovf     (stk_ovf),
    .unf     (stk_unf)
  );

  // A failed (empty) pop does not assert pop_vld, so it falls through here.
  always_comb begin
    flags_nxt = flags_out;
    if (pop_vld)
      flags_nxt = stk_dout;
    else if (psw_ld)
      flags_nxt = psw_din;
    else if (flags_we)
      flags_nxt = (flags_out & ~flags_mask) | (flags_in & flags_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flags_out <= '0;
    else
      flags_out <= flags_nxt & FLAG_RSV_MASK;
  end

  assign cond_true = eval_cond(flags_out, cond_sel);

endmodule

// File: tb/tb_alu_flag_reg.sv
// Self-checking bench for alu_flag_reg: expected status pushed to a
// scoreboard when each cycle's stimulus is driven, popped after the edge.
module tb_alu_flag_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] flags_in;
  logic       flags_we;
  logic [7:0] flags_mask;
  logic       psw_ld;
  logic [7:0] psw_din;
  logic       push;
  logic       pop;
  logic       err_clr;
  logic [2:0] cond_sel;
  logic [7:0] flags_out;
  logic       cond_true;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_ovf;
  logic       stk_unf;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];

  alu_flag_reg #(.DEPTH(4), .FLAG_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flags_in   (flags_in),
    .flags_we   (flags_we),
    .flags_mask (flags_mask),
    .psw_ld     (psw_ld),
    .psw_din    (psw_din),
    .push       (push),
    .pop        (pop),
    .err_clr    (err_clr),
    .cond_sel   (cond_sel),
    .flags_out  (flags_out),
    .cond_true  (cond_true),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed status packed as {flags_out, full, empty, ovf, unf}
  function automatic logic [11:0] obs();
    return {flags_out, stk_full, stk_empty, stk_ovf, stk_unf};
  endfunction

  task automatic idle();
    flags_in = 8'h00; flags_we = 1'b0; flags_mask = 8'h00;
    psw_ld = 1'b0; psw_din = 8'h00; push = 1'b0; pop = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_st(input string nm, input logic [7:0] f, input logic fu,
                           input logic em, input logic ov, input logic un);
    exp_q.push_back({f, fu, em, ov, un});
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    logic [11:0] e;
    string       nm;
    rst_n = 1'b0; idle(); cond_sel = 3'd0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (obs() !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_init: got %h want %h", obs(), {8'h00, 4'b0100});
    end
    flags_we = 1'b1; flags_mask = 8'hFF; flags_in = 8'hE3; push = 1'b1;
    expect_st("capture_e3_push", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    // Asynchronous reset mid-run, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_async: got %h want %h", obs(), {8'h00, 4'b0100});
    end
    @(negedge clk);
    rst_n = 1'b1;
    flags_we = 1'b1; flags_mask = 8'hFF; flags_in = 8'hE3;
    expect_st("capture_after_reset", 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
  endtask

  task automatic test_masked_cond();
    logic [11:0] e;
    string       nm;
    logic [7:0]  sels;
    logic [7:0]  want_1f;
    flags_we = 1'b1; flags_mask = 8'h02; flags_in = 8'h00;
    expect_st("masked_capture", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    flags_we = 1'b1; flags_mask = 8'h00; flags_in = 8'hFF;
    expect_st("mask_zero_hold", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    // flags=01 (Z only): sel 0..7 -> 1,1,0,0,1,0,0,0
    sels = 8'b0001_0011;
    for (int i = 0; i < 8; i++) begin
      cond_sel = i[2:0]; #1; checks++;
      if (cond_true !== sels[i]) begin
        errors++; $display("FAIL cond_z_sel%0d: got %b want %b", i, cond_true, sels[i]);
      end
    end
    psw_ld = 1'b1; psw_din = 8'hFF;
    expect_st("psw_ld_ff", 8'h1F, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    // flags=1F: only !Z and !C are false
    want_1f = 8'b1110_1011;
    for (int i = 0; i < 8; i++) begin
      cond_sel = i[2:0]; #1; checks++;
      if (cond_true !== want_1f[i]) begin
        errors++; $display("FAIL cond_1f_sel%0d: got %b want %b", i, cond_true, want_1f[i]);
      end
    end
    cond_sel = 3'd0;
    psw_ld = 1'b1; psw_din = 8'hE0;
    expect_st("psw_ld_reserved", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
  endtask

  task automatic test_fill();
    logic [11:0] e;
    string       nm;
    logic [7:0]  vals[4];
    vals = '{8'h01, 8'h02, 8'h04, 8'h08};
    psw_ld = 1'b1; psw_din = vals[0];
    expect_st("fill_ld01", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    // Each push saves the pre-edge value while psw_ld loads the next one
    for (int i = 1; i < 4; i++) begin
      push = 1'b1; psw_ld = 1'b1; psw_din = vals[i];
      expect_st($sformatf("fill_push%0d", i), vals[i], 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    end
    push = 1'b1;
    expect_st("fill_push4_full", 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    push = 1'b1; psw_ld = 1'b1; psw_din = 8'h11;
    expect_st("push_full_ovf", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    for (int i = 3; i >= 0; i--) begin
      pop = 1'b1;
      expect_st($sformatf("fill_pop%0d", i), vals[i], 1'b0, (i == 0), 1'b1, 1'b0);
      tick();
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    end
    err_clr = 1'b1;
    expect_st("clear_ovf", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
  endtask

  task automatic test_underflow();
    logic [11:0] e;
    string       nm;
    pop = 1'b1;
    expect_st("pop_empty_unf", 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    pop = 1'b1; err_clr = 1'b1;
    expect_st("unf_set_wins", 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    err_clr = 1'b1;
    expect_st("unf_clear", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    pop = 1'b1; flags_we = 1'b1; flags_mask = 8'hFF; flags_in = 8'h06;
    expect_st("pop_empty_fallthru", 8'h06, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    err_clr = 1'b1;
    tick();
    push = 1'b1; pop = 1'b1;
    expect_st("pushpop_empty", 8'h06, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    err_clr = 1'b1;
    tick();
  endtask

  task automatic test_same_cycle();
    logic [11:0] e;
    string       nm;
    psw_ld = 1'b1; psw_din = 8'h05;
    expect_st("sc_ld05", 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    push = 1'b1; flags_we = 1'b1; flags_mask = 8'hFF; flags_in = 8'h10;
    expect_st("push_with_we", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    pop = 1'b1; psw_ld = 1'b1; psw_din = 8'h1F;
    expect_st("pop_beats_psw_ld", 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    psw_ld = 1'b1; psw_din = 8'h08;
    expect_st("sw_ld08", 8'h08, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    push = 1'b1; psw_ld = 1'b1; psw_din = 8'h10;
    expect_st("sw_push08_ld10", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    push = 1'b1; pop = 1'b1;
    expect_st("swap", 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    pop = 1'b1;
    expect_st("swap_top_pop", 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    string       nm;
    logic [7:0]  model;
    logic [7:0]  d;
    logic [7:0]  m;
    model = 8'h10;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      m = 8'($urandom);
      flags_we = 1'b1; flags_in = d; flags_mask = m;
      model = ((model & ~m) | (d & m)) & 8'h1F;
      expect_st($sformatf("b2b_capture%0d", i), model, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL %s: got %h want %h", nm, obs(), e); end
    end
  endtask

  initial begin
    test_reset();
    test_masked_cond();
    test_fill();
    test_underflow();
    test_same_cycle();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d want 0 entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
